// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the mem_arbiter slice.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around mem_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_resp_valid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  ls_req_valid;
  logic                  ls_req_ready;
  logic [ADDR_W-1:0]     ls_addr;
  logic                  ls_wen;
  logic [DATA_W-1:0]     ls_wdata;
  logic [DATA_W/8-1:0]   ls_wmask;
  logic                  ls_resp_valid;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  timeout_err;

  modport master (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output timeout_err
  );

  modport slave (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  timeout_err
  );

endinterface

// File: rtl/mem_arbiter_arb_grant.sv
// Grant picker for the two requesters. MEM_ARB_RR_EN selects round-robin,
// otherwise fixed priority with LSU over IF.
module arb_grant
  import mem_arb_pkg::*;
(
  input  logic   if_valid_i,
  input  logic   ls_valid_i,
  input  logic   en_i,
  input  owner_t last_i,
  output logic   gnt_if_o,
  output logic   gnt_ls_o
);

`ifdef MEM_ARB_RR_EN
  logic prefer_ls;

  // On contention, favour whichever side did not win last time.
  assign prefer_ls = (last_i == OWN_IF);
  assign gnt_ls_o  = en_i & ls_valid_i & (~if_valid_i | prefer_ls);
  assign gnt_if_o  = en_i & if_valid_i & (~ls_valid_i | ~prefer_ls);
`else
  logic unused_last;

  assign unused_last = last_i;
  assign gnt_ls_o    = en_i & ls_valid_i;
  assign gnt_if_o    = en_i & if_valid_i & ~ls_valid_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in
// flight, with a response watchdog. Optional MEM_ARB_RR_EN: round-robin grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  owner_t                last_q, last_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic gnt_if, gnt_ls;
  logic mem_done, tmo_fire, resp_fire;

  // Readys are forced low while reset is held so nothing is offered then.
  arb_grant u_grant (
    .if_valid_i (bus.if_req_valid),
    .ls_valid_i (bus.ls_req_valid),
    .en_i       ((state_q == IDLE) && !reset),
    .last_i     (last_q),
    .gnt_if_o   (gnt_if),
    .gnt_ls_o   (gnt_ls)
  );

  assign mem_done  = (state_q == WAIT) && bus.mem_resp_valid;
  // A real response in the final cycle wins over the abort.
  assign tmo_fire  = ((state_q == REQ) || (state_q == WAIT)) &&
                     (cnt_q == CNT_W'(TIMEOUT - 1)) && !mem_done;
  assign resp_fire = mem_done || tmo_fire;

  assign bus.if_req_ready  = gnt_if;
  assign bus.ls_req_ready  = gnt_ls;
  assign bus.if_resp_valid = resp_fire && (owner_q == OWN_IF);
  assign bus.ls_resp_valid = resp_fire && (owner_q == OWN_LS);
  assign bus.if_rdata      = (mem_done && (owner_q == OWN_IF)) ? bus.mem_rdata : '0;
  assign bus.ls_rdata      = (mem_done && (owner_q == OWN_LS)) ? bus.mem_rdata : '0;

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.timeout_err   = err_q | tmo_fire;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (gnt_ls) begin
          owner_d = OWN_LS;
          last_d  = OWN_LS;
          addr_d  = bus.ls_addr;
          wen_d   = bus.ls_wen;
          wdata_d = bus.ls_wdata;
          wmask_d = bus.ls_wmask;
          cnt_d   = '0;
          state_d = REQ;
        end else if (gnt_if) begin
          owner_d = OWN_IF;
          last_d  = OWN_IF;
          addr_d  = bus.if_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_fire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_done) begin
          state_d = IDLE;
        end else if (tmo_fire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8); contention expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

  localparam logic [63:0] IF_A   = 64'h0000_0000_0000_0100;
  localparam logic [63:0] LS_A   = 64'h0000_0000_0000_0200;
  localparam logic [63:0] F_A    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] F_D    = 64'h0000_0013_0000_0297;
  localparam logic [63:0] ST_A   = 64'h0000_0000_8000_1000;
  localparam logic [63:0] ST_D   = 64'h1122_3344_5566_7788;
  localparam logic [63:0] LD_WD  = 64'hCAFE_F00D_1234_5678;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with the request(s) already driven.
  task automatic txn(input string tag, input bit exp_ls, input logic [63:0] exp_addr,
                     input logic [63:0] d);
    #1;
    chk({tag, ".ls_rdy"}, bus.ls_req_ready, exp_ls);
    chk({tag, ".if_rdy"}, bus.if_req_ready, !exp_ls);
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    chk({tag, ".mreqv"}, bus.mem_req_valid, 1'b1);
    chk({tag, ".maddr"}, bus.mem_addr, exp_addr);
    chk({tag, ".rdy_busy"}, bus.if_req_ready | bus.ls_req_ready, 1'b0);
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = d;
    #1;
    chk({tag, ".ls_resp"}, bus.ls_resp_valid, exp_ls);
    chk({tag, ".if_resp"}, bus.if_resp_valid, !exp_ls);
    chk({tag, ".rdata"}, exp_ls ? bus.ls_rdata : bus.if_rdata, d);
    chk({tag, ".mreqv_w"}, bus.mem_req_valid, 1'b0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    #1;
    chk({tag, ".resp_end"}, bus.if_resp_valid | bus.ls_resp_valid, 1'b0);
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    reset              = 1'b1;
    bus.if_req_valid   = 1'b0;
    bus.if_addr        = '0;
    bus.ls_req_valid   = 1'b0;
    bus.ls_addr        = '0;
    bus.ls_wen         = 1'b0;
    bus.ls_wdata       = '0;
    bus.ls_wmask       = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst.if_rdy", bus.if_req_ready, 1'b0);
    chk("rst.ls_rdy", bus.ls_req_ready, 1'b0);
    chk("rst.mreqv", bus.mem_req_valid, 1'b0);
    chk("rst.maddr", bus.mem_addr, 64'h0);
    chk("rst.terr", bus.timeout_err, 1'b0);
    reset = 1'b0;

    // Contention with both valids held for three transactions.
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = IF_A;
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = LS_A;
    bus.ls_wen       = 1'b0;
`ifdef MEM_ARB_RR_EN
    txn("cont1", 1'b1, LS_A, 64'hA1);
    txn("cont2", 1'b0, IF_A, 64'hA2);
    txn("cont3", 1'b1, LS_A, 64'hA3);
`else
    txn("cont1", 1'b1, LS_A, 64'hA1);
    txn("cont2", 1'b1, LS_A, 64'hA2);
    txn("cont3", 1'b1, LS_A, 64'hA3);
`endif
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;

    // Lone fetch.
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = F_A;
    txn("fetch", 1'b0, F_A, F_D);
    bus.if_req_valid = 1'b0;

    // Store right away: exercises the 3-cycle turnaround and field stability.
    bus.ls_req_valid = 1'b1;
    bus.ls_wen       = 1'b1;
    bus.ls_addr      = ST_A;
    bus.ls_wdata     = ST_D;
    bus.ls_wmask     = 8'h0F;
    #1;
    chk("st.turnaround", bus.ls_req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ls_req_valid = 1'b0;
      bus.ls_wen       = 1'b0;
      bus.ls_addr      = '1;
      bus.ls_wdata     = '0;
      bus.ls_wmask     = 8'hFF;
      #1;
      chk("st.mreqv", bus.mem_req_valid, 1'b1);
      chk("st.maddr", bus.mem_addr, ST_A);
      chk("st.mwdata", bus.mem_wdata, ST_D);
      chk("st.mwmask", bus.mem_wmask, 8'h0F);
      chk("st.mwen", bus.mem_wen, 1'b1);
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    chk("st.hs", bus.mem_req_valid, 1'b1);
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h55;
    #1;
    chk("st.ack", bus.ls_resp_valid, 1'b1);
    chk("st.if_quiet", bus.if_resp_valid, 1'b0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("st.ack_end", bus.ls_resp_valid, 1'b0);

    // Watchdog: response in REQ is ignored, memory never answers in WAIT.
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'h40;
    #1;
    chk("wd.rdy", bus.if_req_ready, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      bus.if_req_valid   = 1'b0;
      bus.mem_req_ready  = (i == 2);
      bus.mem_resp_valid = (i == 1);
      bus.mem_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      chk("wd.no_resp", bus.if_resp_valid, 1'b0);
      chk("wd.no_err", bus.timeout_err, 1'b0);
    end
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("wd.fire_resp", bus.if_resp_valid, 1'b1);
    chk("wd.fire_rdata", bus.if_rdata, 64'h0);
    chk("wd.fire_err", bus.timeout_err, 1'b1);
    chk("wd.ls_quiet", bus.ls_resp_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("wd.resp_end", bus.if_resp_valid, 1'b0);
    chk("wd.err_sticky", bus.timeout_err, 1'b1);
    chk("wd.idle", bus.mem_req_valid, 1'b0);
    bus.mem_rdata    = '0;
    bus.ls_req_valid = 1'b1;
    bus.ls_wen       = 1'b0;
    bus.ls_addr      = 64'h300;
    txn("wd_after", 1'b1, 64'h300, 64'h77);
    bus.ls_req_valid = 1'b0;
    chk("wd.err_still", bus.timeout_err, 1'b1);

    // Reset asserted mid-WAIT.
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = 64'h400;
    bus.ls_wdata     = LD_WD;
    bus.ls_wmask     = 8'hFF;
    #1;
    chk("rw.rdy", bus.ls_req_ready, 1'b1);
    @(negedge clk);
    bus.ls_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    chk("rw.maddr", bus.mem_addr, 64'h400);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    chk("rw.wait", bus.mem_req_valid, 1'b0);
    #2;
    reset              = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h99;
    #1;
    chk("rw.if_rdy", bus.if_req_ready, 1'b0);
    chk("rw.ls_rdy", bus.ls_req_ready, 1'b0);
    chk("rw.if_resp", bus.if_resp_valid, 1'b0);
    chk("rw.ls_resp", bus.ls_resp_valid, 1'b0);
    chk("rw.if_rdata", bus.if_rdata, 64'h0);
    chk("rw.ls_rdata", bus.ls_rdata, 64'h0);
    chk("rw.mreqv", bus.mem_req_valid, 1'b0);
    chk("rw.maddr0", bus.mem_addr, 64'h0);
    chk("rw.mwen", bus.mem_wen, 1'b0);
    chk("rw.mwdata", bus.mem_wdata, 64'h0);
    chk("rw.mwmask", bus.mem_wmask, 8'h00);
    chk("rw.terr", bus.timeout_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw.post_ls", bus.ls_resp_valid, 1'b0);
    chk("rw.post_if", bus.if_resp_valid, 1'b0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    bus.if_req_valid   = 1'b1;
    bus.if_addr        = 64'h500;
    txn("post_rst", 1'b0, 64'h500, 64'h1234);
    bus.if_req_valid = 1'b0;
    chk("post_rst.terr", bus.timeout_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
